// File: rtl/arm_mc_controller_if.sv
// Control bundle between the multicycle ARM controller and its shared-memory datapath.
// The controller side uses the master modport; the datapath (or a bench) uses slave.
interface arm_mc_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic [2:0]  ALUControl;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic        RegWrite;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite
    );
endinterface

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: one FSM, condition flags and condition-gated writes.
// Optional performance counters are enabled with `define ARM_MC_PERF_EN.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4
// DECODE | read registers, route on op
// EXECR  | ALU op with register operand
// EXECI  | ALU op with immediate operand
// ALUWB  | write ALU result to Rd
// MEMADR | compute load/store address
// MEMRD  | read data memory
// MEMWB  | write loaded data to Rd
// MEMWR  | write data memory
// BRANCH | PC <= branch target
module arm_mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    arm_mc_controller_if.master  bus
`ifdef ARM_MC_PERF_EN
    ,
    output logic [31:0]          CycleCount,
    output logic [31:0]          InstrCount
`endif
);

    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  flags_q;
    logic        cond_ex, cond_ex_q;
    logic [2:0]  alu_dec;
    logic        no_write;
    logic [1:0]  flag_w;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [3:0]  cmd;
    logic        s_bit, funct5;
    logic        n_f, z_f, c_f, v_f;
    logic        in_exec;
    logic        unused_instr;

    assign cond   = bus.Instr[19:16];
    assign op     = bus.Instr[15:14];
    assign funct5 = bus.Instr[13];
    assign cmd    = bus.Instr[12:9];
    assign s_bit  = bus.Instr[8];
    assign {n_f, z_f, c_f, v_f} = flags_q;
    assign in_exec = (state_q == EXECR) || (state_q == EXECI);
    assign unused_instr = ^bus.Instr[7:0];

    always_comb begin
        alu_dec  = 3'b000;
        no_write = 1'b1;
        flag_w   = 2'b00;
        case (cmd)
            4'b0100: begin alu_dec = 3'b000; no_write = 1'b0; flag_w = {s_bit, s_bit}; end
            4'b0010: begin alu_dec = 3'b001; no_write = 1'b0; flag_w = {s_bit, s_bit}; end
            4'b0000: begin alu_dec = 3'b010; no_write = 1'b0; flag_w = {s_bit, 1'b0}; end
            4'b1100: begin alu_dec = 3'b011; no_write = 1'b0; flag_w = {s_bit, 1'b0}; end
            4'b1010: begin alu_dec = 3'b001; no_write = 1'b1; flag_w = 2'b11; end
            default: begin alu_dec = 3'b000; no_write = 1'b1; flag_w = 2'b00; end
        endcase
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // cond_ex_q freezes the EXEC-time verdict so ALUWB is not affected by flags the
    // same instruction just wrote.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else if (in_exec) begin
            cond_ex_q <= cond_ex;
            if (cond_ex && flag_w[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (cond_ex && flag_w[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    logic       pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write;
    logic [1:0] result_src, alu_src_b;
    logic [2:0] alu_control;

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_control = 3'b000;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        reg_write   = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b00:   state_d = funct5 ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            EXECR: begin
                alu_control = alu_dec;
                state_d     = ALUWB;
            end
            EXECI: begin
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write = cond_ex_q & ~no_write;
                state_d   = FETCH;
            end
            MEMADR: begin
                alu_src_b = 2'b01;
                state_d   = s_bit ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = cond_ex;
                state_d    = FETCH;
            end
            MEMWR: begin
                adr_src   = 1'b1;
                mem_write = cond_ex;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_ex;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    assign bus.PCWrite    = pc_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_control;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
    assign bus.RegWrite   = reg_write;

`ifdef ARM_MC_PERF_EN
    logic [31:0] cycle_count, instr_count;
    logic        terminal;

    assign terminal = (state_q == ALUWB) || (state_q == MEMWB) || (state_q == MEMWR) ||
                      (state_q == BRANCH) || ((state_q == DECODE) && (op == 2'b11));

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (terminal) instr_count <= instr_count + 32'd1;
        end
    end

    assign CycleCount = cycle_count;
    assign InstrCount = instr_count;
`endif

endmodule

// File: tb/tb_arm_mc_controller.sv
// Scoreboard bench for arm_mc_controller: a per-instruction reference model pushes
// expected control vectors; a negedge monitor pops and compares them.
module tb_arm_mc_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_mc_controller_if bus();

`ifdef ARM_MC_PERF_EN
    logic [31:0] cyc, icnt;
    arm_mc_controller dut (.clk(clk), .reset(reset), .bus(bus), .CycleCount(cyc), .InstrCount(icnt));
`else
    arm_mc_controller dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    typedef struct {
        logic [16:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam int F = 0, D = 1, ER = 2, EI = 3, WB = 4, MA = 5, MR = 6, MWB = 7, MWR = 8, BR = 9;
    string step_name [10] = '{"fetch", "decode", "execr", "execi", "aluwb",
                              "memadr", "memrd", "memwb", "memwr", "branch"};

    logic [3:0] flags_m;

    // ARM condition semantics: bits [3:1] pick a test, bit [0] inverts it.
    function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
        bit n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: return c[0] == 1'b0;
        endcase
        return c[0] ? !r : r;
    endfunction

    function automatic logic [16:0] mkv(bit pcw, bit adr, bit mw, bit irw, logic [1:0] rs,
                                        logic [2:0] alu, bit sa, logic [1:0] sb,
                                        logic [19:0] ins, bit rw);
        logic [1:0] op;
        op = ins[15:14];
        return {pcw, adr, mw, irw, rs, alu, sa, sb, op, op == 2'b01, op == 2'b10, rw};
    endfunction

    task automatic run_instr(input logic [19:0] ins, input logic [3:0] exec_flags, input int abort_at);
        int         path[$];
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] cmd;
        bit         pass, is_cmp, legal, nz_w, cv_w, nowrite;
        logic [2:0] alu;
        logic [16:0] v;
        op  = ins[15:14];
        fn  = ins[13:8];
        cmd = fn[4:1];
        pass = cond_ok(ins[19:16], flags_m);
        is_cmp = (cmd == 4'b1010);
        legal  = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) || (cmd == 4'b1100);
        alu = (cmd == 4'b0010 || is_cmp) ? 3'b001 : (cmd == 4'b0000) ? 3'b010 :
              (cmd == 4'b1100) ? 3'b011 : 3'b000;
        nowrite = !legal;
        nz_w = is_cmp || (fn[0] && legal);
        cv_w = nz_w && (cmd == 4'b0100 || cmd == 4'b0010 || is_cmp);
        path = '{F, D};
        case (op)
            2'b00: begin path.push_back(fn[5] ? EI : ER); path.push_back(WB); end
            2'b01: begin
                path.push_back(MA);
                if (fn[0]) begin path.push_back(MR); path.push_back(MWB); end
                else path.push_back(MWR);
            end
            2'b10: path.push_back(BR);
            default: ;
        endcase
        for (int k = 0; k < path.size(); k++) begin
            bus.Instr    = ins;
            bus.ALUFlags = (path[k] == ER || path[k] == EI) ? exec_flags : 4'($urandom);
            case (path[k])
                F:   v = mkv(1, 0, 0, 1, 2'b10, 3'b000, 1, 2'b10, ins, 0);
                D:   v = mkv(0, 0, 0, 0, 2'b10, 3'b000, 1, 2'b10, ins, 0);
                ER:  v = mkv(0, 0, 0, 0, 2'b00, alu,    0, 2'b00, ins, 0);
                EI:  v = mkv(0, 0, 0, 0, 2'b00, alu,    0, 2'b01, ins, 0);
                WB:  v = mkv(0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, ins, pass && !nowrite);
                MA:  v = mkv(0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b01, ins, 0);
                MR:  v = mkv(0, 1, 0, 0, 2'b00, 3'b000, 0, 2'b00, ins, 0);
                MWB: v = mkv(0, 0, 0, 0, 2'b01, 3'b000, 0, 2'b00, ins, pass);
                MWR: v = mkv(0, 1, pass, 0, 2'b00, 3'b000, 0, 2'b00, ins, 0);
                default: v = mkv(pass, 0, 0, 0, 2'b10, 3'b000, 0, 2'b01, ins, 0);
            endcase
            exp_q.push_back('{v: v, name: step_name[path[k]]});
            if ((path[k] == ER || path[k] == EI) && pass) begin
                if (nz_w) flags_m[3:2] = exec_flags[3:2];
                if (cv_w) flags_m[1:0] = exec_flags[1:0];
            end
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset   = 1'b0;
                flags_m = 4'b0000;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [19:0] mk(logic [3:0] c, logic [1:0] op, logic [5:0] fn);
        return {c, op, fn, 8'($urandom)};
    endfunction

    initial begin : monitor
        logic [16:0] act;
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                       bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc, bus.RegWrite};
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %05h expected %05h at %0t", e.name, act, e.v, $time);
                end
            end
        end
    end

    initial begin : driver
        reset        = 1'b1;
        bus.Instr    = 20'h0;
        bus.ALUFlags = 4'h0;
        flags_m      = 4'h0;
        @(posedge clk); #1;
        exp_q.push_back('{v: mkv(1, 0, 0, 1, 2'b10, 3'b000, 1, 2'b10, 20'h0, 0), name: "reset_fetch"});
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(mk(4'hE, 2'b00, 6'b101000), 4'h0, -1);   // ADD R1,R2,#5
        run_instr(mk(4'hE, 2'b01, 6'b011001), 4'h0, -1);   // LDR
        run_instr(mk(4'hE, 2'b10, 6'b100000), 4'h0, -1);   // B
`ifdef ARM_MC_PERF_EN
        checks++;
        if (icnt !== 32'd3) begin errors++; $display("FAIL instr_count: got %0d expected 3", icnt); end
        checks++;
        if (cyc !== 32'd12) begin errors++; $display("FAIL cycle_count: got %0d expected 12", cyc); end
`endif
        run_instr(mk(4'hE, 2'b00, 6'b000101), 4'b0100, -1); // SUBS -> Z
        run_instr(mk(4'h0, 2'b10, 6'b100000), 4'h0, -1);    // BEQ taken
        run_instr(mk(4'h1, 2'b10, 6'b100000), 4'h0, -1);    // BNE not taken
        run_instr(mk(4'hE, 2'b01, 6'b011000), 4'h0, -1);    // STR
        run_instr(mk(4'hE, 2'b00, 6'b010101), 4'b1000, -1); // CMP -> N
        run_instr(mk(4'hE, 2'b00, 6'b001000), 4'b0110, -1); // ADD no S
        run_instr(mk(4'h4, 2'b10, 6'b100000), 4'h0, -1);    // BMI taken
        run_instr(mk(4'h0, 2'b10, 6'b100000), 4'h0, -1);    // BEQ not taken
        run_instr(mk(4'hE, 2'b00, 6'b000101), 4'b0100, -1); // SUBS -> Z
        run_instr(mk(4'hE, 2'b01, 6'b011001), 4'h0, 3);     // LDR, reset in MEMRD
        run_instr(mk(4'h0, 2'b10, 6'b100000), 4'h0, -1);    // BEQ after reset: flags cleared
        run_instr(mk(4'hE, 2'b11, 6'b111111), 4'h0, -1);    // illegal op
        run_instr(mk(4'hF, 2'b00, 6'b101000), 4'h0, -1);    // cond 1111 never executes

        for (int i = 0; i < 300; i++)
            run_instr(20'($urandom), 4'($urandom), -1);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected vectors left unchecked", exp_q.size());
        end

`ifdef ARM_MC_PERF_EN
        #1;
        force dut.cycle_count = 32'hFFFF_FFFF;
        #2;
        release dut.cycle_count;
        @(posedge clk); #1;
        checks++;
        if (cyc !== 32'd0) begin errors++; $display("FAIL cycle_wrap: got %08h expected 00000000", cyc); end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
- Multicycle control unit for the ARM core.
- Sequences a shared-memory datapath through fetch, decode, execute, memory and writeback states with one FSM.
- Owns the condition-flag register and gates every architectural write with the condition check.
- Drives the multicycle datapath's muxes, write enables and 3-bit ALUControl; the datapath returns ALUFlags.

Parameters:
- STATE_W, 4, width of state register; 10 states used.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Instr  in  20  Instr[31:12] from instruction register: cond[19:16], op[15:14], funct[13:8], Rd[7:4]
- ALUFlags  in  4  {N,Z,C,V} from ALU, same cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4
- ImmSrc  out  2  equal to op
- RegSrc  out  2  [0]=1 when op=10 (branch), [1]=1 when op=01 (memory)
- RegWrite  out  1  register file write enable

Behaviour:
Clocking and reset:
- Single clock domain; all state updates on posedge clk.
- reset=1 at any edge, including mid-instruction: state←FETCH, Flags←0000.
- All write enables are combinational from state, so they are 0 during reset cycles except IRWrite/PCWrite, which assert in the first FETCH after reset is released.

States (one-hot transitions, binary encoding allowed):
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 (unconditional) → DECODE
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. Next state:
  - op=00, funct[5]=0 → EXECR
  - op=00, funct[5]=1 → EXECI
  - op=01 → MEMADR
  - op=10 → BRANCH
  - op=11 → FETCH (illegal, no writes)
- EXECR: ALUSrcA=0, ALUSrcB=00, ALU decode → ALUWB
- EXECI: ALUSrcA=0, ALUSrcB=01, ALU decode → ALUWB
- ALUWB: ResultSrc=00, RegWrite=CondEx & ~NoWrite → FETCH
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next state: funct[0]=1 → MEMRD; funct[0]=0 → MEMWR
- MEMRD: AdrSrc=1, ResultSrc=00 → MEMWB
- MEMWB: ResultSrc=01, RegWrite=CondEx → FETCH
- MEMWR: AdrSrc=1, MemWrite=CondEx → FETCH
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx → FETCH
- Unlisted outputs are 0 in each state.

Latency:
- B: 3 cycles; data-processing: 4; STR: 4; LDR: 5; illegal op: 2.

ALU decode (EXECR/EXECI only; cmd=funct[4:1], S=funct[0]):
- 0100 ADD→000
- 0010 SUB→001
- 0000 AND→010
- 1100 ORR→011
- 1010 CMP→001 with NoWrite=1 and flags always updated
- Any other cmd: ALUControl=000, NoWrite=1, no flag update

Flags:
- FlagW[1] (N,Z) = S or CMP.
- FlagW[0] (C,V) = (S or CMP) and cmd is ADD, SUB or CMP.
- Flags[3:2] update from ALUFlags[3:2] on clk edge in EXECR/EXECI when FlagW[1] & CondEx; Flags[1:0] likewise with FlagW[0].
- Flags are held in all other states.
- A write to the flags in EXEC is visible to the next instruction's CondEx, not the current one.

CondEx:
- Combinational from cond and registered Flags, covering all 15 ARM codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
- cond=1111 → CondEx=0.
- Failed condition: the FSM still walks the full path; only RegWrite/MemWrite/PCWrite(branch)/flag writes are suppressed.

Optional Feature:
- Macro: ARM_MC_PERF_EN
- Defined:
  - Adds outputs CycleCount[31:0] and InstrCount[31:0], both 0 on reset.
  - CycleCount increments every non-reset cycle.
  - InstrCount increments on each transition into FETCH from a terminal state (ALUWB, MEMWB, MEMWR, BRANCH, DECODE-illegal), regardless of CondEx.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset held 2 cycles, then release, Instr=ADD R1,R2,#5 (cond=1110, op=00, funct=101000) → PCWrite/IRWrite=1 in cycle 0; EXECI in cycle 2 with ALUControl=000, ALUSrcB=01; RegWrite=1 in cycle 3 only; back to FETCH in cycle 4.
- SUBS with ALUFlags=0100 → Flags=0100 after EXECR. Next instruction BEQ → PCWrite=1 in BRANCH. Same with BNE → PCWrite=0 in BRANCH; FSM still returns to FETCH.
- LDR (op=01, funct[0]=1) → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. STR → MemWrite=1 only in MEMWR, 4 cycles total.
- CMP R1,R2 with ALUFlags=1000 → Flags=1000; RegWrite=0 in ALUWB. ADD without S and ALUFlags=0110 → Flags unchanged.
- reset asserted during MEMRD → next cycle state=FETCH, Flags=0000, RegWrite never asserted. Illegal op=11 → DECODE returns to FETCH with all writes 0.
- ARM_MC_PERF_EN defined: run ADD, LDR, B (4+5+3 cycles) → InstrCount=3, CycleCount=12. Preload counter to 0xFFFFFFFF via force → wraps to 0.
